// File: rtl/clk_reset_sequencer.sv
// Board-level reset sequencer and clock-enable generator.
// Waits for a filtered PLL lock, stretches reset, then runs NUM_CE clock-enable
// dividers and a heartbeat. Any lock loss in RUN drops back to WAIT_LOCK.

// One divide-by-DIV channel. hit_d is the registered-next strobe: high on the
// cycle that will be the DIV-th, 2*DIV-th, ... RUN cycle. DIV=0 never hits.
module clk_reset_sequencer_div #(
    parameter int             W   = 16,
    parameter logic [W-1:0]   DIV = '0
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic run_d,
    output logic hit_d
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] nxt;

    // Count RUN cycles modulo DIV; counter parks at 0 whenever not running
    always_comb begin
        hit_d = 1'b0;
        cnt_d = '0;
        nxt   = cnt_q + W'(1);
        if (run_d && (DIV != '0)) begin
            if (nxt == DIV) begin
                hit_d = 1'b1;
            end else begin
                cnt_d = nxt;
            end
        end
    end

    // Divider count register
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

module clk_reset_sequencer #(
    parameter int                        LOCK_FILTER  = 16,
    parameter int                        RESET_CYCLES = 65536,
    parameter int                        NUM_CE       = 3,
    parameter int                        DIV_W        = 16,
    parameter logic [NUM_CE*DIV_W-1:0]   CE_DIV       = {16'd0, 16'd1, 16'd5},
    parameter int                        HB_DIV       = 6000000,
    parameter int                        CNT_W        = 8
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              pll_lock_in,
    output logic              reset_out,
    output logic              ready_out,
    output logic [NUM_CE-1:0] ce_out,
    output logic              heartbeat_out,
    output logic [CNT_W-1:0]  lock_loss_cnt_out,
    output logic [1:0]        state_out
);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STRETCH   = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    localparam int FLT_W = (LOCK_FILTER > 1)  ? $clog2(LOCK_FILTER)  : 1;
    localparam int STR_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int HB_W  = $clog2(HB_DIV + 1);

    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOCK_FILTER - 1);
    localparam logic [STR_W-1:0] STR_LAST = STR_W'(RESET_CYCLES - 1);

    state_t              state_q, state_d;
    logic [FLT_W-1:0]    flt_q, flt_d;
    logic [STR_W-1:0]    str_q, str_d;
    logic [CNT_W-1:0]    llc_q, llc_d;
    logic                reset_q, reset_d;
    logic                ready_q, ready_d;
    logic [NUM_CE-1:0]   ce_q, ce_d;
    logic                hb_q, hb_d;
    logic                run_d;
    logic [NUM_CE-1:0]   ce_hit;
    logic                hb_hit;

    // Sequencer: lock filter, reset stretch, run; lock loss counted only from RUN
    always_comb begin
        state_d = state_q;
        flt_d   = '0;
        str_d   = '0;
        llc_d   = llc_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (pll_lock_in) begin
                    if (flt_q == FLT_LAST) begin
                        state_d = ST_STRETCH;
                    end else begin
                        flt_d = flt_q + FLT_W'(1);
                    end
                end
            end
            ST_STRETCH: begin
                if (!pll_lock_in) begin
                    state_d = ST_WAIT_LOCK;
                end else if (str_q == STR_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    str_d = str_q + STR_W'(1);
                end
            end
            ST_RUN: begin
                if (!pll_lock_in) begin
                    state_d = ST_WAIT_LOCK;
                    if (llc_q != '1) begin
                        llc_d = llc_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_WAIT_LOCK;
        endcase
    end

    // Outputs are registered, so they are derived from the next state
    always_comb begin
        run_d   = (state_d == ST_RUN);
        reset_d = !run_d;
        ready_d = run_d;
        ce_d    = ce_hit;
        hb_d    = run_d ? (hb_q ^ hb_hit) : 1'b0;
    end

    for (genvar i = 0; i < NUM_CE; i++) begin : g_ce
        clk_reset_sequencer_div #(
            .W   (DIV_W),
            .DIV (CE_DIV[i*DIV_W +: DIV_W])
        ) u_div (
            .clk_in   (clk_in),
            .reset_in (reset_in),
            .run_d    (run_d),
            .hit_d    (ce_hit[i])
        );
    end

    clk_reset_sequencer_div #(
        .W   (HB_W),
        .DIV (HB_W'(HB_DIV))
    ) u_hb_div (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .run_d    (run_d),
        .hit_d    (hb_hit)
    );

    // State, counters and output registers; reset_in overrides everything
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= ST_WAIT_LOCK;
            flt_q   <= '0;
            str_q   <= '0;
            llc_q   <= '0;
            reset_q <= 1'b1;
            ready_q <= 1'b0;
            ce_q    <= '0;
            hb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            flt_q   <= flt_d;
            str_q   <= str_d;
            llc_q   <= llc_d;
            reset_q <= reset_d;
            ready_q <= ready_d;
            ce_q    <= ce_d;
            hb_q    <= hb_d;
        end
    end

    assign reset_out         = reset_q;
    assign ready_out         = ready_q;
    assign ce_out            = ce_q;
    assign heartbeat_out     = hb_q;
    assign lock_loss_cnt_out = llc_q;
    assign state_out         = state_q;

endmodule
